cache_line_refill_ctrl: RTL
===========================

Name: cache_line_refill_ctrl

Overview:
- Miss-handling sequencer for one data-cache line built from the distributed-RAM cache-line store (tag/valid/dirty registers plus 16 x 32-bit words).
- On a miss request it writes the victim line back over an AXI write burst if the line is valid and dirty. It then refills the line over an AXI read burst and installs the new tag.
- Sits between the cache hit/miss logic and the AXI master bridge. It owns the line's write port and read offset while busy.

Parameters:
- TAG_WIDTH, 20, tag bits held by the line.
- INDEX_WIDTH, 6, set-index bits used to form burst addresses.
- CACHE_LINE_WIDTH, 6, log2 of line bytes (64 B).
- OFFSET_WIDTH, CACHE_LINE_WIDTH-2, word-offset bits (16 words).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- miss_req  in  1  start miss handling (sampled in IDLE only)
- miss_tag  in  TAG_WIDTH  tag of the missing address
- miss_index  in  INDEX_WIDTH  set index of the missing address
- busy  out  1  controller not in IDLE
- done  out  1  one-cycle pulse when the line is refilled
- line_rtag  in  TAG_WIDTH  current line tag
- line_rdata  in  32  line word at line_roff (asynchronous read)
- line_rdirty  in  1  current line dirty flag
- line_rvalid  in  1  current line valid flag
- line_roff  out  OFFSET_WIDTH  read offset driven to the line
- line_we  out  1  line write enable
- line_wtag  out  TAG_WIDTH  tag written to the line
- line_woff  out  OFFSET_WIDTH  word offset written
- line_wdata  out  32  data written
- line_wbe  out  4  byte enables
- line_wdirty  out  1  dirty value written
- line_wvalid  out  1  valid value written
- awaddr  out  32  write-burst address
- awlen  out  8  write-burst length
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wlast  out  1  last write beat
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bvalid  in  1  write response valid
- bready  out  1  write response ready
- araddr  out  32  read-burst address
- arlen  out  8  read-burst length
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  32  read data
- rlast  in  1  last read beat
- rvalid  in  1  read data valid
- rready  out  1  read data ready

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, beat counter 0. All valid/ready/we/done/busy outputs are 0. Addresses and latched tag/index are 0. Reset mid-burst abandons the transaction immediately, and the line keeps whatever it already holds.
- States: IDLE, WB_AW, WB_W, WB_B, RF_AR, RF_R, DONE.
- IDLE:
  - On miss_req, latch miss_tag, miss_index, line_rtag.
  - Go to WB_AW if line_rvalid && line_rdirty, else RF_AR.
  - No bus activity in the request cycle.
- WB_AW:
  - awvalid=1, awaddr={victim_tag, index, 6'b0}, awlen=15.
  - On awready, clear the counter and go to WB_W.
- WB_W:
  - line_roff=cnt, wdata=line_rdata (combinational), wvalid=1, wlast=(cnt==15).
  - Each wvalid&&wready increments cnt. wdata and roff hold stable while wready=0.
  - Go to WB_B after beat 15.
- WB_B: bready=1; on bvalid go to RF_AR. bresp is ignored.
- RF_AR:
  - arvalid=1, araddr={miss_tag, index, 6'b0}, arlen=15.
  - On arready, clear cnt and go to RF_R.
- RF_R:
  - rready=1.
  - Each rvalid beat drives line_we=1, line_woff=cnt, line_wdata=rdata, line_wbe=4'hF, line_wtag=miss_tag, line_wdirty=0, line_wvalid=(cnt==15), then increments cnt.
  - The line is therefore invalid mid-refill.
  - The 16th beat ends the burst and moves to DONE. cnt is authoritative; rlast is not used for control.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- awvalid and arvalid hold high until accepted; the address stays constant while valid.
- miss_req outside IDLE is ignored.
- A clean or invalid victim skips WB_* entirely.
- cnt is OFFSET_WIDTH wide and wraps 15→0 only after a state exit.
- line_we is 0 in every state except RF_R, so there are no spurious line writes.

Decomposition:
- Shared package cache_pkg:
  - state encoding
  - BURST_LEN=16
  - AXI constants: ARSIZE=3'b010, ARBURST_INCR=2'b01, AWLEN/ARLEN value 8'd15
- Sub-module cache_beat_counter: an OFFSET_WIDTH-bit counter with clear/increment/last flag. It is reused by both burst phases.

Test Plan:
- Clean miss: line valid=1, dirty=0, miss_tag=0x12345, index=3. Expect no awvalid; araddr=0x123450C0, arlen=15. Sixteen beats with data i*0x11 land at woff i; line_wvalid=1 only on beat 15; done pulses 1 cycle after.
- Dirty miss: victim tag 0xABCDE, index 1, words 0..15. Expect awaddr=0xABCDE040; wdata sequence matches line words; wlast on beat 15; bready until bvalid; then refill as above.
- Backpressure: wready toggles 1/0 and rvalid is sparse. Expect wdata/line_roff held while stalled, exactly 16 beats each, and no duplicate line writes.
- Invalid line with dirty=1: expect writeback skipped and refill only.
- miss_req pulsed during RF_R: expect it to be ignored, with one done pulse only.
- rst_n=0 during WB_W beat 7: expect all outputs 0 next cycle and IDLE. A subsequent miss_req restarts cleanly from WB_AW.

Source files
------------

// File: rtl/cache_line_refill_ctrl_pkg.sv
// Shared definitions for the single-line miss sequencer: FSM encoding and AXI burst constants.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_AW,
        ST_WB_W,
        ST_WB_B,
        ST_RF_AR,
        ST_RF_R,
        ST_DONE
    } state_e;

    localparam int         BURST_LEN    = 16;
    localparam logic [2:0] ARSIZE       = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [7:0] AXLEN        = 8'd15;

endpackage

// File: rtl/cache_line_refill_ctrl_beat_counter.sv
// Word-offset beat counter shared by the writeback and refill bursts.
module cache_beat_counter
    import cache_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign last = (cnt == W'(BURST_LEN - 1));

endmodule

// File: rtl/cache_line_refill_ctrl.sv
// Miss sequencer for one cache line: optional dirty-victim writeback burst, then refill burst and tag install.
module cache_line_refill_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH        = 20,
    parameter int INDEX_WIDTH      = 6,
    parameter int CACHE_LINE_WIDTH = 6,
    parameter int OFFSET_WIDTH     = CACHE_LINE_WIDTH - 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_req,
    input  logic [TAG_WIDTH-1:0]    miss_tag,
    input  logic [INDEX_WIDTH-1:0]  miss_index,
    output logic                    busy,
    output logic                    done,
    input  logic [TAG_WIDTH-1:0]    line_rtag,
    input  logic [31:0]             line_rdata,
    input  logic                    line_rdirty,
    input  logic                    line_rvalid,
    output logic [OFFSET_WIDTH-1:0] line_roff,
    output logic                    line_we,
    output logic [TAG_WIDTH-1:0]    line_wtag,
    output logic [OFFSET_WIDTH-1:0] line_woff,
    output logic [31:0]             line_wdata,
    output logic [3:0]              line_wbe,
    output logic                    line_wdirty,
    output logic                    line_wvalid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    state_e                  state_q, state_d;
    logic [TAG_WIDTH-1:0]    tag_q, victim_q;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic                    cnt_clr, cnt_inc, cnt_last;
    logic [OFFSET_WIDTH-1:0] cnt;

    // The beat count alone terminates the refill, so rlast is not needed for control.
    logic unused_ok;
    assign unused_ok = &{1'b0, rlast, ARSIZE, ARBURST_INCR};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tag_q    <= '0;
            victim_q <= '0;
            index_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && miss_req) begin
                tag_q    <= miss_tag;
                victim_q <= line_rtag;
                index_q  <= miss_index;
            end
        end
    end

    cache_beat_counter #(.W(OFFSET_WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Addresses come straight from the latched registers, so they cannot move while valid is high.
    assign awaddr    = {victim_q, index_q, {CACHE_LINE_WIDTH{1'b0}}};
    assign araddr    = {tag_q, index_q, {CACHE_LINE_WIDTH{1'b0}}};
    assign awlen     = AXLEN;
    assign arlen     = AXLEN;
    assign line_roff = cnt;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        done        = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        wdata       = '0;
        wlast       = 1'b0;
        bready      = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        line_we     = 1'b0;
        line_wtag   = '0;
        line_woff   = '0;
        line_wdata  = '0;
        line_wbe    = '0;
        line_wdirty = 1'b0;
        line_wvalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_req) state_d = (line_rvalid && line_rdirty) ? ST_WB_AW : ST_RF_AR;
            end
            ST_WB_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    cnt_clr = 1'b1;
                    state_d = ST_WB_W;
                end
            end
            ST_WB_W: begin
                wvalid = 1'b1;
                wdata  = line_rdata;
                wlast  = cnt_last;
                if (wready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = ST_WB_B;
                end
            end
            ST_WB_B: begin
                bready = 1'b1;
                if (bvalid) state_d = ST_RF_AR;
            end
            ST_RF_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    cnt_clr = 1'b1;
                    state_d = ST_RF_R;
                end
            end
            ST_RF_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    // Valid is written only with the last word, so the line reads invalid mid-refill.
                    line_we     = 1'b1;
                    line_woff   = cnt;
                    line_wdata  = rdata;
                    line_wbe    = 4'hF;
                    line_wtag   = tag_q;
                    line_wvalid = cnt_last;
                    cnt_inc     = 1'b1;
                    if (cnt_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
